tick_gen: RTL and testbench

Multi-channel programmable tick/strobe generator running on the 5 MHz game clock. Each channel produces a one-cycle tick enable and a 50%-duty square wave at a runtime-programmable rate. It replaces fixed single-rate dividers for the game's movement, animation and blink timing. Supports per-channel pause, global resync, and stepwise speed-up so that the game accelerates as levels advance.

---
 rtl/tick_gen_pkg.sv | 51 +++++
 rtl/tick_chan.sv | 101 ++++++++++
 rtl/tick_gen.sv | 73 +++++++
 tb/tb_tick_gen.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen_pkg
// Description : Shared constants, config-operation encoding and divisor
//               helper functions for the multi-channel tick generator.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_gen_pkg;

  // Game master clock frequency
  localparam int unsigned CLK_HZ   = 5000000;
  // Reset divisor: 4 Hz tick at the 5 MHz game clock
  localparam int unsigned DEF_DIV  = 1250000;
  // Smallest legal divisor; 2 keeps ticks from ever landing back-to-back
  localparam int unsigned MIN_DIV  = 2;
  // Amount removed from a divisor by one speed-up pulse
  localparam int unsigned DEC_STEP = 62500;

  // Per-channel configuration operation decoded from cfg_we / cfg_dec.
  // A write always beats a decrement, so at most one op reaches a channel.
  typedef enum logic [1:0] {
    CFG_NONE  = 2'd0,
    CFG_WRITE = 2'd1,
    CFG_DEC   = 2'd2
  } cfg_op_e;

  // Divisor producing the requested tick rate at the game clock
  function automatic int unsigned hz_to_div(input int unsigned hz);
    return (hz == 0) ? CLK_HZ : (CLK_HZ / hz);
  endfunction

  // Raise a divisor to the floor value if it is below it
  function automatic logic [31:0] clamp_div(input logic [31:0] val,
                                            input logic [31:0] floor_val);
    return (val < floor_val) ? floor_val : val;
  endfunction

  // max(val - step, floor_val) without ever wrapping below zero
  function automatic logic [31:0] sat_dec(input logic [31:0] val,
                                          input logic [31:0] step,
                                          input logic [31:0] floor_val);
    logic [31:0] diff;
    if (val < step) begin
      return floor_val;
    end
    diff = val - step;
    return clamp_div(diff, floor_val);
  endfunction

endpackage : tick_gen_pkg
`default_nettype wire

// File: rtl/tick_chan.sv
`default_nettype none
// ============================================================================
// Module      : tick_chan
// Description : One tick generator channel. A free-running counter wraps
//               every 'active' cycles, issuing a one-cycle tick and toggling
//               a square wave. New divisors land in a shadow register and
//               are promoted to active only at a wrap or a resync.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_chan #(
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned DEF_DIV  = tick_gen_pkg::DEF_DIV,
  parameter int unsigned MIN_DIV  = tick_gen_pkg::MIN_DIV,
  parameter int unsigned DEC_STEP = tick_gen_pkg::DEC_STEP
) (
  input  logic                  clk_5M,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic                  sync_i,
  input  tick_gen_pkg::cfg_op_e op_i,
  input  logic [CNT_W-1:0]      wdata_i,
  output logic                  tick_o,
  output logic                  sq_o,
  output logic [CNT_W-1:0]      active_o
);
  import tick_gen_pkg::*;

  // CNT_W is limited to 32 bits by the 32-bit divisor helpers
  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             tick_q,   tick_d;
  logic             sq_q,     sq_d;
  logic             wrap;

  // Last cycle of the current period; cnt never exceeds active-1 because
  // active only changes together with a counter clear
  assign wrap = (cnt_q == (active_q - ONE));

  // Shadow divisor update: clamped write or floored decrement
  always_comb begin
    shadow_d = shadow_q;
    case (op_i)
      CFG_WRITE: shadow_d = CNT_W'(clamp_div(32'(wdata_i), 32'(MIN_DIV)));
      CFG_DEC:   shadow_d = CNT_W'(sat_dec(32'(shadow_q), 32'(DEC_STEP),
                                           32'(MIN_DIV)));
      default:   shadow_d = shadow_q;
    endcase
  end

  // Counter / tick / square-wave next state; resync beats counting.
  // On resync the freshly updated shadow is taken so a same-cycle
  // write or speed-up applies immediately; at a normal wrap the value
  // already sitting in the shadow is promoted.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    sq_d     = sq_q;
    tick_d   = 1'b0;
    if (sync_i) begin
      cnt_d    = '0;
      sq_d     = 1'b0;
      active_d = shadow_d;
    end else if (en_i) begin
      if (wrap) begin
        cnt_d    = '0;
        tick_d   = 1'b1;
        sq_d     = ~sq_q;
        active_d = shadow_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // Channel state registers with synchronous reset to the default rate
  always_ff @(posedge clk_5M) begin
    if (reset) begin
      cnt_q    <= '0;
      shadow_q <= DEF_VAL;
      active_q <= DEF_VAL;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
    end
  end

  assign tick_o   = tick_q;
  assign sq_o     = sq_q;
  assign active_o = active_q;

endmodule : tick_chan
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Multi-channel programmable tick / square-wave generator for
//               the 5 MHz game clock. Decodes the shared config port into a
//               per-channel operation, fans out run/enable and resync, and
//               packs the active divisors onto div_q (channel 0 in LSBs).
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned CNT_W    = 24,
  parameter  int unsigned DEF_DIV  = tick_gen_pkg::DEF_DIV,
  parameter  int unsigned MIN_DIV  = tick_gen_pkg::MIN_DIV,
  parameter  int unsigned DEC_STEP = tick_gen_pkg::DEC_STEP,
  localparam int unsigned SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_5M,
  input  logic                    reset,
  input  logic                    run,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    sync,
  input  logic                    cfg_we,
  input  logic [SEL_W-1:0]        cfg_ch,
  input  logic [CNT_W-1:0]        cfg_div,
  input  logic                    cfg_dec,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq,
  output logic [NUM_CH*CNT_W-1:0] div_q
);
  import tick_gen_pkg::*;

  cfg_op_e op_sel;

  // Collapse the two config strobes into one op; a write drops a decrement
  always_comb begin
    op_sel = CFG_NONE;
    if (cfg_we) begin
      op_sel = CFG_WRITE;
    end else if (cfg_dec) begin
      op_sel = CFG_DEC;
    end
  end

  // One channel per tick output. A cfg_ch value with no matching channel
  // hits nothing, so out-of-range writes and decrements vanish.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cfg_op_e op_ch;
    logic    hit;

    assign hit   = (cfg_ch == SEL_W'(i));
    assign op_ch = hit ? op_sel : CFG_NONE;

    tick_chan #(
      .CNT_W    (CNT_W),
      .DEF_DIV  (DEF_DIV),
      .MIN_DIV  (MIN_DIV),
      .DEC_STEP (DEC_STEP)
    ) u_chan (
      .clk_5M   (clk_5M),
      .reset    (reset),
      .en_i     (run & ch_en[i]),
      .sync_i   (sync),
      .op_i     (op_ch),
      .wdata_i  (cfg_div),
      .tick_o   (tick[i]),
      .sq_o     (sq[i]),
      .active_o (div_q[i*CNT_W +: CNT_W])
    );
  end : g_ch

endmodule : tick_gen
`default_nettype wire

// File: tb/tb_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tick_gen
// Description : Scoreboard bench for tick_gen. Stimulus queues hand-computed
//               tick cycles and state snapshots; a monitor compares them
//               against the DUT outputs away from the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;
  localparam int SEL_W  = 2;
  localparam int DEFV   = 1250000;

  logic                    clk_5M = 1'b0;
  logic                    reset;
  logic                    run;
  logic [NUM_CH-1:0]       ch_en;
  logic                    sync;
  logic                    cfg_we;
  logic [SEL_W-1:0]        cfg_ch;
  logic [CNT_W-1:0]        cfg_div;
  logic                    cfg_dec;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       sq;
  logic [NUM_CH*CNT_W-1:0] div_q;

  tick_gen dut (
    .clk_5M  (clk_5M),
    .reset   (reset),
    .run     (run),
    .ch_en   (ch_en),
    .sync    (sync),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_dec (cfg_dec),
    .tick    (tick),
    .sq      (sq),
    .div_q   (div_q)
  );

  // 5 MHz clock
  always #100 clk_5M = ~clk_5M;

  // Cycle number = count of rising edges so far
  int cyc = 0;
  always @(posedge clk_5M) cyc <= cyc + 1;

  typedef struct {
    int ch;
    bit tk;
    bit s;
    int div;
  } snap_t;

  int    tick_q [NUM_CH][$];
  snap_t snap_q [$];
  bit    watch  [NUM_CH];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Monitor: tick scoreboard for watched channels plus snapshot compares
  always @(negedge clk_5M) begin : mon
    snap_t s;
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (watch[i]) begin
        while (tick_q[i].size() > 0 && tick_q[i][0] < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL tick_missed ch%0d: no tick seen, required at cycle %0d (now %0d)",
                   i, tick_q[i][0], cyc);
          void'(tick_q[i].pop_front());
        end
        if (tick[i]) begin
          n_checks++;
          if (tick_q[i].size() == 0 || tick_q[i][0] != cyc) begin
            n_fail++;
            $display("FAIL tick_unexpected ch%0d: tick at cycle %0d, next required %0d",
                     i, cyc, (tick_q[i].size() > 0) ? tick_q[i][0] : -1);
          end else begin
            void'(tick_q[i].pop_front());
          end
        end
      end
    end
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      n_checks++;
      if (tick[s.ch] !== s.tk || sq[s.ch] !== s.s ||
          div_q[s.ch*CNT_W +: CNT_W] !== CNT_W'(s.div)) begin
        n_fail++;
        $display("FAIL snap ch%0d cyc %0d: got tick=%0b sq=%0b div=%0d, required tick=%0b sq=%0b div=%0d",
                 s.ch, cyc, tick[s.ch], sq[s.ch], div_q[s.ch*CNT_W +: CNT_W],
                 s.tk, s.s, s.div);
      end
    end
  end

  task automatic step();
    @(negedge clk_5M);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_5M);
  endtask

  task automatic snap(input int ch, input bit tk, input bit s, input int div);
    snap_q.push_back('{ch, tk, s, div});
  endtask

  task automatic push_ticks(input int ch, input int first, input int period,
                            input int count);
    for (int k = 0; k < count; k++) tick_q[ch].push_back(first + k * period);
  endtask

  task automatic cfg_write(input int ch, input int val);
    cfg_we  = 1'b1;
    cfg_ch  = SEL_W'(ch);
    cfg_div = CNT_W'(val);
    step();
    cfg_we  = 1'b0;
  endtask

  // Pulse sync for one cycle; returns the cycle it was driven in
  task automatic do_sync(output int t);
    sync = 1'b1;
    t    = cyc;
    step();
    sync = 1'b0;
  endtask

  // Close a scoreboard window: stop watching and require nothing left over
  task automatic close_window();
    for (int i = 0; i < NUM_CH; i++) begin
      watch[i] = 1'b0;
      n_checks++;
      if (tick_q[i].size() != 0) begin
        n_fail++;
        $display("FAIL window_drain ch%0d: %0d ticks outstanding, required 0",
                 i, tick_q[i].size());
        tick_q[i].delete();
      end
    end
  endtask

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t;
    int t0;
    reset   = 1'b1;
    run     = 1'b0;
    ch_en   = '0;
    sync    = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    cfg_dec = 1'b0;
    for (int i = 0; i < NUM_CH; i++) watch[i] = 1'b0;

    // Reset state
    repeat (3) step();
    for (int i = 0; i < NUM_CH; i++) snap(i, 1'b0, 1'b0, DEFV);
    reset = 1'b0;
    step();

    // Phase A: every channel at divisor 4 -> tick every 4, sq period 8
    for (int i = 0; i < NUM_CH; i++) cfg_write(i, 4);
    run   = 1'b1;
    ch_en = '1;
    do_sync(t);
    snap(0, 1'b0, 1'b0, 4);
    for (int i = 0; i < NUM_CH; i++) begin
      push_ticks(i, t + 5, 4, 6);
      watch[i] = 1'b1;
    end
    wait_until(t + 5);
    snap(0, 1'b1, 1'b1, 4);
    snap(3, 1'b1, 1'b1, 4);
    wait_until(t + 8);
    snap(0, 1'b0, 1'b1, 4);
    wait_until(t + 9);
    snap(0, 1'b1, 1'b0, 4);
    wait_until(t + 26);
    close_window();

    // Phase B: ch1 rewritten to 10 mid-period; current period still ends at 4
    do_sync(t);
    push_ticks(0, t + 5, 4, 6);
    push_ticks(1, t + 5, 10, 3);
    watch[0] = 1'b1;
    watch[1] = 1'b1;
    wait_until(t + 2);
    cfg_write(1, 10);
    wait_until(t + 4);
    snap(1, 1'b0, 1'b0, 4);
    wait_until(t + 5);
    snap(1, 1'b1, 1'b1, 10);
    wait_until(t + 14);
    snap(1, 1'b0, 1'b1, 10);
    wait_until(t + 15);
    snap(1, 1'b1, 1'b0, 10);
    wait_until(t + 26);
    close_window();

    // Phase C: divisors 0 and 1 are floored to 2
    cfg_write(2, 0);
    cfg_write(3, 1);
    do_sync(t);
    snap(2, 1'b0, 1'b0, 2);
    snap(3, 1'b0, 1'b0, 2);
    push_ticks(2, t + 3, 2, 9);
    push_ticks(3, t + 3, 2, 9);
    watch[2] = 1'b1;
    watch[3] = 1'b1;
    wait_until(t + 3);
    snap(2, 1'b1, 1'b1, 2);
    wait_until(t + 4);
    snap(2, 1'b0, 1'b1, 2);
    wait_until(t + 20);
    close_window();

    // Phase D: speed-up steps 150000 -> 87500 -> 25000 -> 2, write beats dec
    cfg_write(0, 150000);
    do_sync(t);
    snap(0, 1'b0, 1'b0, 150000);
    cfg_dec = 1'b1;
    cfg_ch  = 2'd0;
    step();
    cfg_dec = 1'b0;
    do_sync(t);
    snap(0, 1'b0, 1'b0, 87500);
    snap(1, 1'b0, 1'b0, 10);
    cfg_dec = 1'b1;
    do_sync(t);
    cfg_dec = 1'b0;
    snap(0, 1'b0, 1'b0, 25000);
    cfg_dec = 1'b1;
    do_sync(t);
    cfg_dec = 1'b0;
    snap(0, 1'b0, 1'b0, 2);
    cfg_we  = 1'b1;
    cfg_div = CNT_W'(7);
    cfg_dec = 1'b1;
    do_sync(t);
    cfg_we  = 1'b0;
    cfg_dec = 1'b0;
    snap(0, 1'b0, 1'b0, 7);

    // Phase E: ch2 at divisor 6 paused for 7 cycles -> tick 7 cycles late
    cfg_write(2, 6);
    do_sync(t);
    push_ticks(2, t + 14, 6, 3);
    watch[2] = 1'b1;
    wait_until(t + 3);
    ch_en = 4'b1011;
    wait_until(t + 8);
    snap(2, 1'b0, 1'b0, 6);
    wait_until(t + 10);
    ch_en = 4'b1111;
    wait_until(t + 13);
    snap(2, 1'b0, 1'b0, 6);
    wait_until(t + 14);
    snap(2, 1'b1, 1'b1, 6);
    wait_until(t + 27);
    close_window();

    // Phase F: channels drift apart, then resync aligns them
    cfg_write(0, 3);
    cfg_write(1, 5);
    cfg_write(2, 5);
    cfg_write(3, 5);
    do_sync(t0);
    wait_until(t0 + 8);
    snap(1, 1'b0, 1'b1, 5);
    do_sync(t);
    snap(0, 1'b0, 1'b0, 3);
    for (int i = 1; i < NUM_CH; i++) snap(i, 1'b0, 1'b0, 5);
    push_ticks(0, t + 4, 3, 3);
    for (int i = 1; i < NUM_CH; i++) push_ticks(i, t + 6, 5, 2);
    for (int i = 0; i < NUM_CH; i++) watch[i] = 1'b1;
    wait_until(t + 6);
    for (int i = 1; i < NUM_CH; i++) snap(i, 1'b1, 1'b1, 5);
    wait_until(t + 12);
    close_window();

    // Reset mid-count: ch0 would otherwise tick on the next edge
    reset = 1'b1;
    step();
    for (int i = 0; i < NUM_CH; i++) snap(i, 1'b0, 1'b0, DEFV);
    reset = 1'b0;
    step();
    step();
    snap(0, 1'b0, 1'b0, DEFV);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tick_gen
`default_nettype wire
